// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin, packet-locked arbiter sharing the write port of one async FIFO
//   among NREQ requesters. Everything runs on the FIFO write clock. Once a
//   requester is granted it keeps the FIFO until it transfers a word flagged
//   last, so packets never interleave inside the FIFO.
//
// Ports
//   wrclk     in   1           FIFO write clock, rising edge
//   reset     in   1           asynchronous, active-high reset
//   reqvalid  in   NREQ        per-requester word valid
//   reqlast   in   NREQ        per-requester end-of-packet, qualified by reqvalid
//   reqdata   in   NREQ*WIDTH  requester i at bits [i*WIDTH +: WIDTH]
//   reqready  out  NREQ        per-requester accept
//   full      in   1           registered FIFO full flag (wrclk domain)
//   wr        out  1           FIFO write strobe
//   datain    out  WIDTH       FIFO write data (0 outside XFER)
//   busy      out  1           high while a grant is held (state XFER); this is
//                              also the observable FSM state
//   grant_id  out  IDW         current or last granted requester
//
// Handshake: a word moves from requester i when reqvalid[i] & reqready[i] are
// both high at a rising edge of wrclk. reqready only ever rises for the granted
// requester while full is low; requesters hold valid/data/last until accepted.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    wrclk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         reqvalid,
  input  logic [NREQ-1:0]         reqlast,
  input  logic [NREQ*WIDTH-1:0]   reqdata,
  output logic [NREQ-1:0]         reqready,
  input  logic                    full,
  output logic                    wr,
  output logic [WIDTH-1:0]        datain,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   rr_last;

  logic             any_valid;
  logic [IDW-1:0]   next_grant;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;

  // Round-robin pick: walk candidates from farthest (rr_last itself) down to
  // nearest (rr_last+1), so the nearest valid requester is the last one to
  // overwrite next_grant and therefore wins. The requester just served ends up
  // with the lowest priority.
  always_comb begin : pick
    int idx;
    idx        = 0;
    any_valid  = 1'b0;
    next_grant = rr_last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(rr_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == idx && reqvalid[i]) begin
          any_valid  = 1'b1;
          next_grant = IDW'(i);
        end
      end
    end
  end

  // Mux of the granted requester's signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_valid = reqvalid[i];
        sel_last  = reqlast[i];
        sel_data  = reqdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // full is registered inside the FIFO, so gating on it here is enough to
  // guarantee no write is ever presented while the FIFO reports full.
  always_comb begin
    reqready = '0;
    if (state == XFER && !full) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id == IDW'(i)) reqready[i] = 1'b1;
      end
    end
  end

  assign busy   = (state == XFER);
  assign wr     = busy & sel_valid & ~full;
  // Drive zero outside XFER so no X ever reaches the FIFO data path.
  assign datain = busy ? sel_data : '0;

  always_ff @(posedge wrclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_last  <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= next_grant;
            rr_last  <= next_grant;
            state    <= XFER;
          end
        end
        XFER: begin
          // wr already implies the granted requester's transfer happened.
          if (wr && sel_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
